// File: rtl/jtframe_pll_cen.sv
// jtframe_pll_cen: fractional clock-enable generator gated by PLL lock.
// cen[0] pulses at an average rate of clk*n/m once the PLL has held lock for
// SETTLE cycles. cen[1] is cen[0] divided by two. A lock loss while running
// stops the enables and leaves a sticky lock_lost flag.
module jtframe_pll_cen #(
  parameter int W      = 10,
  parameter int SETTLE = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         locked,
  input  logic [W-1:0] n,
  input  logic [W-1:0] m,
  output logic [1:0]   cen,
  output logic         ready,
  output logic         lock_lost
);

  localparam logic [1:0]  WAIT_LOCK   = 2'd0;
  localparam logic [1:0]  SETTLE_ST   = 2'd1;
  localparam logic [1:0]  RUN         = 2'd2;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  // SETTLE=1 needs no settle cycles at all: lock seen in WAIT_LOCK is enough.
  localparam logic [1:0]  AFTER_WAIT  = (SETTLE == 1) ? RUN : SETTLE_ST;

  logic         lk_meta_reg;
  logic         lk_s;
  logic [1:0]   state_reg;
  logic [15:0]  settle_cnt_reg;
  logic [W-1:0] n_r;
  logic [W-1:0] m_r;
  logic [W-1:0] acc;
  logic [W:0]   sum;
  logic         half_reg;
  logic         run_ok;
  logic         changed;

  // Two-flop synchroniser for the asynchronous PLL lock signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_reg <= 1'b0;
      lk_s        <= 1'b0;
    end else begin
      lk_meta_reg <= locked;
      lk_s        <= lk_meta_reg;
    end
  end

  // Lock supervision: wait for lock, let it settle, run until it drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= WAIT_LOCK;
      settle_cnt_reg <= 16'd0;
      lock_lost      <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          settle_cnt_reg <= 16'd0;
          if (lk_s) state_reg <= AFTER_WAIT;
        end
        SETTLE_ST: begin
          if (lk_s) begin
            settle_cnt_reg <= settle_cnt_reg + 16'd1;
            if (settle_cnt_reg + 16'd1 == SETTLE_LAST) state_reg <= RUN;
          end else begin
            // Lock was never trusted yet, so this is not a lock loss.
            state_reg      <= WAIT_LOCK;
            settle_cnt_reg <= 16'd0;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_reg <= WAIT_LOCK;
            lock_lost <= 1'b1;
          end
        end
        default: state_reg <= WAIT_LOCK;
      endcase
    end
  end

  assign ready   = (state_reg == RUN);
  // Datapath only advances on edges where the state stays in RUN.
  assign run_ok  = (state_reg == RUN) && lk_s;
  assign changed = (n != n_r) || (m != m_r);
  // One extra bit so acc+n never wraps before the comparison against m.
  assign sum     = {1'b0, acc} + {1'b0, n_r};

  // Fractional accumulator and registered enable outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r      <= '0;
      m_r      <= '0;
      acc      <= '0;
      half_reg <= 1'b0;
      cen      <= 2'b00;
    end else begin
      n_r <= n;
      m_r <= m;
      if (!run_ok) begin
        acc      <= '0;
        half_reg <= 1'b0;
        cen      <= 2'b00;
      end else if (changed) begin
        // Ratio just changed: restart the phase cleanly, no pulse this edge.
        acc <= '0;
        cen <= 2'b00;
      end else if (n_r == '0) begin
        cen <= 2'b00;
      end else if ((m_r == '0) || (n_r >= m_r)) begin
        // Ratio of one or more saturates to an enable on every cycle.
        acc      <= '0;
        cen[0]   <= 1'b1;
        cen[1]   <= ~half_reg;
        half_reg <= ~half_reg;
      end else if (sum >= {1'b0, m_r}) begin
        acc      <= W'(sum - {1'b0, m_r});
        cen[0]   <= 1'b1;
        cen[1]   <= ~half_reg;
        half_reg <= ~half_reg;
      end else begin
        acc <= sum[W-1:0];
        cen <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_pll_cen.sv
// Testbench for jtframe_pll_cen: a reference model predicts
// {ready, lock_lost, cen} per clock edge into a queue, and a monitor compares
// the DUT outputs against it on the falling edge. Directed phases add explicit
// timing and rate checks; random phases vary n, m and lock glitches.
module tb_jtframe_pll_cen;

  localparam int W      = 10;
  localparam int SETTLE = 4;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         locked = 1'b0;
  logic [W-1:0] n      = W'(1);
  logic [W-1:0] m      = W'(8);
  logic [1:0]   cen;
  logic         ready;
  logic         lock_lost;

  jtframe_pll_cen #(.W(W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .locked    (locked),
    .n         (n),
    .m         (m),
    .cen       (cen),
    .ready     (ready),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Reference model state.
  bit     ref_l1, ref_l2;      // locked as seen one and two edges ago
  int     ref_ones;            // consecutive synchronised-lock cycles seen
  bit     ref_run, ref_lost, ref_half;
  longint ref_t;               // RUN edges since phase restart
  int     ref_nr, ref_mr;      // ratio values seen on the previous edge

  // Enable event at step t of a stable ratio: the integer part of t*n/m steps.
  function automatic bit ref_pulse(longint t, longint nn, longint mm);
    if (nn == 0) return 1'b0;
    if (mm == 0 || nn >= mm) return 1'b1;
    return ((t * nn) / mm) != (((t - 1) * nn) / mm);
  endfunction

  task automatic model_step();
    bit lk_pre, chg, p, c1;
    p  = 1'b0;
    c1 = 1'b0;
    if (!rst_n) begin
      ref_l1 = 0; ref_l2 = 0; ref_ones = 0; ref_run = 0; ref_lost = 0;
      ref_half = 0; ref_t = 0; ref_nr = 0; ref_mr = 0;
      exp_q.push_back(4'b0000);
      return;
    end
    lk_pre = ref_l2;
    ref_l2 = ref_l1;
    ref_l1 = locked;
    chg = (int'(n) != ref_nr) || (int'(m) != ref_mr);
    if (ref_run) begin
      if (!lk_pre) begin
        ref_run = 0; ref_lost = 1; ref_ones = 0; ref_half = 0;
      end else if (chg) begin
        ref_t = 0;
      end else begin
        ref_t++;
        p = ref_pulse(ref_t, ref_nr, ref_mr);
        if (p) begin
          c1 = !ref_half;
          ref_half = !ref_half;
        end
      end
    end else begin
      if (lk_pre) begin
        ref_ones++;
        if (ref_ones >= SETTLE) begin
          ref_run = 1; ref_t = 0; ref_ones = 0;
        end
      end else begin
        ref_ones = 0;
      end
    end
    ref_nr = int'(n);
    ref_mr = int'(m);
    exp_q.push_back({ref_run, ref_lost, c1, p});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compare DUT outputs with the oldest prediction.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ready, lock_lost, cen} !== e) begin
          errors++;
          $display("FAIL sb t=%0t got ready/lost/cen=%b required=%b", $time,
                   {ready, lock_lost, cen}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, first, cnt, last, adj, bad, low_e, hi_e, len;

    // Reset state.
    tick(3);
    chk("reset_out", 64'({ready, lock_lost, cen}), 0);
    $display("phase reset: outputs=%b", {ready, lock_lost, cen});

    // Lock from cycle 0: ready after SETTLE+2 edges.
    rst_n  = 1'b1;
    locked = 1'b1;
    rise   = 0;
    for (int e = 1; e <= 50; e++) begin
      tick(1);
      if (ready) begin rise = e; break; end
    end
    chk("ready_edge", rise, SETTLE + 2);
    $display("phase lock: ready on edge %0d", rise);

    // n=1, m=8: first enable 8 edges after ready.
    first = 0;
    for (int e = 1; e <= 40; e++) begin
      tick(1);
      if (cen[0]) begin first = e; break; end
    end
    chk("first_cen_1_8", first, 8);
    tick(40);
    $display("phase 1/8: first cen after %0d edges", first);

    // n=3, m=10 over 1000 RUN cycles.
    n = W'(3); m = W'(10);
    tick(1);
    chk("chg_edge_cen", 64'(cen), 0);
    cnt = 0; last = -1; adj = 0; bad = 0;
    for (int e = 1; e <= 1000; e++) begin
      tick(1);
      if (cen[0]) begin
        cnt++;
        if (last >= 0) begin
          if (e - last == 1) adj++;
          if (e - last < 3 || e - last > 4) bad++;
        end
        last = e;
      end
    end
    chk("pulses_3_10", cnt, 300);
    chk("adjacent_3_10", adj, 0);
    chk("spacing_3_10", bad, 0);
    $display("phase 3/10: %0d pulses in 1000 cycles", cnt);

    // Saturated ratios.
    n = W'(5); m = W'(5);
    tick(20);
    $display("phase 5/5 done");
    n = W'(7); m = W'(0);
    tick(20);
    $display("phase 7/0 done");

    // m changed 8 -> 6 mid-RUN.
    n = W'(1); m = W'(8);
    tick(20);
    m = W'(6);
    tick(1);
    chk("m_change_cen", 64'(cen), 0);
    first = 0;
    for (int e = 1; e <= 30; e++) begin
      tick(1);
      if (cen[0]) begin first = e; break; end
    end
    chk("first_cen_1_6", first, 6);
    tick(20);
    $display("phase m 8->6: first cen after %0d edges", first);

    // One-cycle lock drop mid-RUN.
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    low_e = 0; hi_e = 0;
    for (int e = 1; e <= 40; e++) begin
      tick(1);
      if (!ready && low_e == 0) low_e = e;
      if (ready && low_e != 0) begin hi_e = e; break; end
    end
    chk("drop_low_edge", low_e, 2);
    chk("relock_edge", hi_e, SETTLE + 2);
    chk("lock_lost_sticky", 64'(lock_lost), 1);
    $display("phase lock drop: low at %0d, ready again at %0d", low_e, hi_e);

    // Random ratios with occasional lock glitches.
    repeat (10) begin
      n   = W'($urandom_range(0, 24));
      m   = W'($urandom_range(0, 24));
      len = $urandom_range(20, 80);
      if ($urandom_range(0, 3) == 0) begin
        tick(len / 2);
        locked = 1'b0;
        tick($urandom_range(1, 3));
        locked = 1'b1;
        tick(len / 2);
      end else begin
        tick(len);
      end
      $display("phase random: n=%0d m=%0d len=%0d", n, m, len);
    end

    // n=0 never enables.
    for (int e = 1; e <= 40; e++) begin
      if (ready) break;
      tick(1);
    end
    chk("wait_ready_n0", 64'(ready), 1);
    n = W'(0); m = W'(5);
    tick(1);
    cnt = 0;
    for (int e = 1; e <= 30; e++) begin
      tick(1);
      if (cen != 2'b00) cnt++;
    end
    chk("n0_pulses", cnt, 0);
    $display("phase n=0: %0d pulses", cnt);

    // Asynchronous reset mid-RUN.
    n = W'(1); m = W'(1);
    tick(5);
    chk("pre_reset_ready", 64'(ready), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset", 64'({ready, lock_lost, cen}), 0);
    tick(3);
    rst_n = 1'b1;
    rise  = 0;
    for (int e = 1; e <= 50; e++) begin
      tick(1);
      if (ready) begin rise = e; break; end
    end
    chk("post_reset_ready", rise, SETTLE + 2);
    tick(10);
    $display("phase async reset: ready again on edge %0d", rise);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
